ddr2_ex_pattern_ctl: RTL



---
 rtl/ddr2_ex_pattern_ctl_if.sv | 24 ++
 rtl/ddr2_ex_pattern_ctl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ddr2_ex_pattern_ctl_if.sv
// Local-interface request/return bundle between the pattern controller and the DDR2 controller.
// master = pattern controller (issues requests), slave = memory controller side.
interface ddr2_ex_pattern_ctl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 24
);
  logic              local_ready;
  logic              local_write_req;
  logic              local_read_req;
  logic [ADDR_W-1:0] local_addr;
  logic [DATA_W-1:0] local_wdata;
  logic              local_rdata_valid;
  logic [DATA_W-1:0] local_rdata;

  modport master (
    input  local_ready, local_rdata_valid, local_rdata,
    output local_write_req, local_read_req, local_addr, local_wdata
  );

  modport slave (
    output local_ready, local_rdata_valid, local_rdata,
    input  local_write_req, local_read_req, local_addr, local_wdata
  );
endinterface

// File: rtl/ddr2_ex_pattern_ctl.sv
// LFSR write/read-back pattern tester: one beat per cycle when local_ready is high,
// requests held stable while local_ready is low; read data checked in return order.
module ddr2_ex_pattern_ctl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 24,
  parameter int SEED   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  ddr2_ex_pattern_ctl_if.master lcl,
  output logic              busy,
  output logic              done,
  output logic              pass_flag,
  output logic              fail_flag,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int L = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_WAIT_RD, S_DONE
  } state_t;

  function automatic logic [DATA_W-1:0] f_seed();
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < L; i++) v[8*i +: 8] = 8'((SEED + i) % 256);
    return v;
  endfunction

  localparam logic [DATA_W-1:0] SEED_VEC = f_seed();

  // Per-lane 8-bit Galois step; lanes are independent.
  function automatic logic [DATA_W-1:0] f_step(input logic [DATA_W-1:0] o);
    logic [DATA_W-1:0] n;
    logic [7:0]        b;
    n = '0;
    for (int i = 0; i < L; i++) begin
      b = o[8*i +: 8];
      n[8*i +: 8] = {b[6], b[5], b[4], b[3] ^ b[7], b[2] ^ b[7], b[1] ^ b[7], b[0], b[7]};
    end
    return n;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base, r_num, r_cnt, r_ret, r_first;
  logic [DATA_W-1:0] r_wbank, r_cbank;
  logic [15:0]       r_err;
  logic              r_pass, r_fail;

  logic w_start, w_wr_acc, w_rd_acc, w_last, w_cmp, w_mismatch, w_rd_done;

  assign w_start    = (r_state == S_IDLE) && start;
  assign w_wr_acc   = (r_state == S_WRITE) && lcl.local_ready;
  assign w_rd_acc   = (r_state == S_READ) && lcl.local_ready;
  assign w_last     = (r_cnt == r_num - ADDR_W'(1));
  // Returns beyond the expected count are dropped so the final verdict cannot shift.
  assign w_cmp      = ((r_state == S_READ) || (r_state == S_WAIT_RD)) &&
                      lcl.local_rdata_valid && (r_ret != r_num);
  assign w_mismatch = w_cmp && (lcl.local_rdata != r_cbank);
  assign w_rd_done  = (r_state == S_WAIT_RD) && (r_ret == r_num);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = (num_words == '0) ? S_DONE : S_WRITE;
      S_WRITE:   if (w_wr_acc && w_last) w_state_nxt = S_READ;
      S_READ:    if (w_rd_acc && w_last) w_state_nxt = S_WAIT_RD;
      S_WAIT_RD: if (w_rd_done) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    lcl.local_write_req = 1'b0;
    lcl.local_read_req  = 1'b0;
    lcl.local_addr      = '0;
    lcl.local_wdata     = '0;
    busy                = (r_state != S_IDLE);
    done                = (r_state == S_DONE);
    case (r_state)
      S_WRITE: begin
        lcl.local_write_req = 1'b1;
        lcl.local_addr      = r_base + r_cnt;
        lcl.local_wdata     = r_wbank;
      end
      S_READ: begin
        lcl.local_read_req = 1'b1;
        lcl.local_addr     = r_base + r_cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base  <= '0;
      r_num   <= '0;
      r_cnt   <= '0;
      r_ret   <= '0;
      r_first <= '0;
      r_err   <= '0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_wbank <= SEED_VEC;
      r_cbank <= SEED_VEC;
    end else if (w_start) begin
      r_base  <= base_addr;
      r_num   <= num_words;
      r_cnt   <= '0;
      r_ret   <= '0;
      r_first <= '0;
      r_err   <= '0;
      r_pass  <= (num_words == '0);
      r_fail  <= 1'b0;
      r_wbank <= SEED_VEC;
      r_cbank <= SEED_VEC;
    end else begin
      if (w_wr_acc) begin
        r_wbank <= f_step(r_wbank);
        r_cnt   <= w_last ? '0 : r_cnt + ADDR_W'(1);
      end
      if (w_rd_acc) r_cnt <= r_cnt + ADDR_W'(1);
      if (w_cmp) begin
        r_cbank <= f_step(r_cbank);
        r_ret   <= r_ret + ADDR_W'(1);
        if (w_mismatch) begin
          if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
          if (r_err == 16'd0)    r_first <= r_base + r_ret;
        end
      end
      // Verdict is registered on the way into DONE so it is visible alongside the pulse.
      if (w_rd_done) begin
        r_pass <= (r_err == 16'd0);
        r_fail <= (r_err != 16'd0);
      end
    end
  end

  assign pass_flag      = r_pass;
  assign fail_flag      = r_fail;
  assign err_count      = r_err;
  assign first_err_addr = r_first;

endmodule
